// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered reservation entries with CDB wake-up,
// oldest-ready selection and compaction on issue.
// Optional macro INT_IQ_BYPASS_EN: select also sees the current-cycle CDB
// broadcast (zero wake-up latency); undefined gives registered wake-up.

package int_iq_pkg;
    localparam int IQ_TAG_W = 6;

    localparam logic [6:0] R_TYPE      = 7'b0110011;
    localparam logic [6:0] I_TYPE      = 7'b0010011;
    localparam logic [6:0] LUI_TYPE    = 7'b0110111;
    localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          func3;
        logic [6:0]          func7;
        logic [31:0]         rs1_data;
        logic [31:0]         rs2_data;
        logic [IQ_TAG_W-1:0] rd_tag;
        logic                wb_valid;
    } int_fifo_data;

    typedef struct packed {
        logic                cdb_valid;
        logic [IQ_TAG_W-1:0] cdb_tag;
        logic [31:0]         cdb_result;
    } cdb_bfm;
endpackage

module int_issue_queue
    import int_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = IQ_TAG_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dispatch_en,
    input  int_fifo_data             dispatch_data,
    input  logic [TAG_W-1:0]         dispatch_rs1_tag,
    input  logic                     dispatch_rs1_rdy,
    input  logic [TAG_W-1:0]         dispatch_rs2_tag,
    input  logic                     dispatch_rs2_rdy,
    input  cdb_bfm                   cdb_in,
    input  logic                     issue_granted,
    output logic                     issue_request,
    output int_fifo_data             int_exec_fifo_data,
    output logic                     queue_full,
    output logic                     queue_empty,
    output logic [$clog2(DEPTH):0]   queue_count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic             valid;
        logic             rs1_rdy;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rs1_tag;
        logic [TAG_W-1:0] rs2_tag;
        int_fifo_data     data;
    } iq_entry_t;

    iq_entry_t     ent_q   [DEPTH];
    iq_entry_t     ent_d   [DEPTH];
    iq_entry_t     snp     [DEPTH+1];   // extra always-empty slot feeds the top on shift
    iq_entry_t     sel_src [DEPTH];
    iq_entry_t     disp_ent;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] wr_slot;
    logic [IW-1:0] sel;
    logic          found, do_issue, do_disp;

    // Capture a matching CDB broadcast into any waiting source of an entry
    function automatic iq_entry_t snoop(input iq_entry_t e, input cdb_bfm c);
        iq_entry_t r;
        r = e;
        if (c.cdb_valid && e.valid) begin
            if (!e.rs1_rdy && e.rs1_tag == TAG_W'(c.cdb_tag)) begin
                r.rs1_rdy       = 1'b1;
                r.data.rs1_data = c.cdb_result;
            end
            if (!e.rs2_rdy && e.rs2_tag == TAG_W'(c.cdb_tag)) begin
                r.rs2_rdy       = 1'b1;
                r.data.rs2_data = c.cdb_result;
            end
        end
        return r;
    endfunction

    // Apply this cycle's CDB to stored entries and to the incoming dispatch
    always_comb begin
        iq_entry_t raw;
        for (int i = 0; i < DEPTH; i++) snp[i] = snoop(ent_q[i], cdb_in);
        snp[DEPTH]  = '0;
        raw         = '0;
        raw.valid   = 1'b1;
        raw.rs1_rdy = dispatch_rs1_rdy;
        raw.rs2_rdy = dispatch_rs2_rdy;
        raw.rs1_tag = dispatch_rs1_tag;
        raw.rs2_tag = dispatch_rs2_tag;
        raw.data    = dispatch_data;
        disp_ent    = snoop(raw, cdb_in);
    end

    // Oldest-ready priority select; bypass build looks at snooped readiness
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef INT_IQ_BYPASS_EN
            sel_src[i] = snp[i];
`else
            sel_src[i] = ent_q[i];
`endif
            if (!found && sel_src[i].valid && sel_src[i].rs1_rdy && sel_src[i].rs2_rdy) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
        issue_request      = found;
        int_exec_fifo_data = found ? sel_src[sel].data : '0;
    end

    // Next queue image: compact above the issued slot, then append dispatch
    always_comb begin
        do_issue = issue_granted & found;
        do_disp  = dispatch_en & (count_q != CW'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            ent_d[i] = (do_issue && IW'(i) >= sel) ? snp[i+1] : snp[i];
        wr_slot = count_q - CW'(do_issue);
        if (do_disp) ent_d[wr_slot[IW-1:0]] = disp_ent;
        count_d = count_q + CW'(do_disp) - CW'(do_issue);
    end

    // Entry and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q <= count_d;
        end
    end

    assign queue_count = count_q;
    assign queue_full  = (count_q == CW'(DEPTH));
    assign queue_empty = (count_q == '0);

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer reservation queue that sits directly upstream of the integer execution unit.
- Accepts dispatched integer, LUI and branch instructions, and snoops the CDB so that pending source operands wake up.
- Each cycle it presents the oldest entry whose operands are both ready, as a packed int_fifo_data word plus an issue request.
- On issue_granted it retires that entry, compacts the queue and frees one slot.

Parameters:
- DEPTH, 4, number of queue entries (power of two, at least 2).
- TAG_W, 6, width of ROB/rename tags on the dispatch and CDB paths.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dispatch_en  input  1  write a new entry this cycle.
- dispatch_data  input  $bits(int_fifo_data)  instruction payload: opcode, func3, func7, rs1/rs2 data, rd_tag, wb_valid.
- dispatch_rs1_tag  input  TAG_W  producer tag for rs1.
- dispatch_rs1_rdy  input  1  rs1_data is already valid.
- dispatch_rs2_tag  input  TAG_W  producer tag for rs2.
- dispatch_rs2_rdy  input  1  rs2_data is already valid.
- cdb_in  input  $bits(cdb_bfm)  CDB broadcast (cdb_valid, cdb_tag, cdb_result).
- issue_granted  input  1  arbiter accepts the presented entry this cycle.
- issue_request  output  1  a ready entry is presented.
- int_exec_fifo_data  output  $bits(int_fifo_data)  payload of the presented entry.
- queue_full  output  1  count == DEPTH.
- queue_empty  output  1  count == 0.
- queue_count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: all entry valid bits 0, count 0, issue_request 0, int_exec_fifo_data all zeros, queue_empty 1, queue_full 0. Reset asserted mid-operation discards all entries immediately.
- Storage: entries are age-ordered with slot 0 as the oldest. Each entry holds the payload, per-source rdy bits and per-source tags.
- Dispatch: when dispatch_en=1 and count < DEPTH (evaluated before this cycle's issue), the entry is written at slot count, or at slot count-1 if an issue also occurs this cycle. Dispatch while full is silently dropped; the dispatcher must watch queue_full. A simultaneous issue does not unblock a dispatch in the same cycle.
- Snoop on stored entries: for each valid entry and each source with rdy=0, if cdb_in.cdb_valid=1 and cdb_in.cdb_tag equals that source's tag, the source data takes cdb_result and rdy goes to 1 at the next edge.
- Snoop at dispatch: the same match is applied to the entry being dispatched in that cycle, so a broadcast coinciding with dispatch is never lost.
- Select: combinational priority encoder picks the lowest-index valid entry with rs1 rdy=1 and rs2 rdy=1.
  - issue_request = selection found.
  - int_exec_fifo_data is driven from the selected entry; it is zero when there is no selection.
- Wake-up latency: rdy bits are registered, so an entry woken by the CDB in cycle N is eligible at the earliest in cycle N+1.
- Issue: when issue_granted=1 and issue_request=1, the selected entry is removed at the edge. Entries above it shift down one slot, keeping age order, and count decrements. issue_granted=1 with issue_request=0 is ignored.
- Simultaneous events: dispatch, CDB capture and issue may all occur in one cycle.
  - Shifting entries carry their CDB-captured values into their new slot.
  - count_next = count + accepted dispatch − accepted issue.
- Branches: BRANCH_TYPE entries are handled identically. Branch ordering relative to younger instructions is enforced by the issue logic, not by this block.
- Flags: queue_full and queue_empty are decoded from the registered count.

Optional Feature:
- Macro INT_IQ_BYPASS_EN.
- When defined, the select logic also treats a source as ready if it matches the current-cycle CDB broadcast. The forwarded cdb_result is muxed into int_exec_fifo_data, so a just-woken entry issues in cycle N with zero wake-up latency.
- When undefined, the behaviour is the registered one-cycle wake-up described above.

Test Plan:
- Reset then dispatch an ADD (R_TYPE, func3=0, func7=0x00) with rs1=5, rs2=7, both rdy, rd_tag=3 -> next cycle issue_request=1, payload rs1_data=5, rs2_data=7; grant -> queue_empty=1 the following cycle.
- Dispatch with rs2 rdy=0, tag=9; two cycles later CDB valid, tag=9, result=0x20 -> issue_request=1 one cycle after the broadcast with rs2_data=0x20 (same cycle if INT_IQ_BYPASS_EN).
- Fill 4 entries, then dispatch a 5th while full -> dropped, count stays 4, queue_full=1. Grant one entry -> count=3, and the next dispatch is accepted.
- Entry0 waiting on tag 4, entry1 ready -> entry1 is presented first. Broadcast tag 4 -> after entry1 is granted, entry0 is presented with the captured data.
- Same cycle: grant entry0, dispatch a new entry, and a CDB hit on entry2's tag -> count unchanged, entry2 shifts to slot1 with the captured data, and the new entry lands in slot count-1.
- Assert rst_n=0 mid-stream with 3 entries valid -> outputs immediately return to reset values, and the queue is empty after rst_n is released.
